// File: rtl/reg_scoreboard.sv
// Register scoreboard for the ID stage: counts in-flight writes per register and
// raises stall on RAW hazards or pending-counter saturation.
module reg_scoreboard #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned REG_COUNT      = 32,
    parameter int unsigned CNT_WIDTH      = 2,
    parameter int unsigned BYPASS_WB      = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic                      id_read_en_1,
    input  logic [REG_ADDR_WIDTH-1:0] id_read_addr_1,
    input  logic                      id_read_en_2,
    input  logic [REG_ADDR_WIDTH-1:0] id_read_addr_2,
    input  logic                      id_write_en,
    input  logic [REG_ADDR_WIDTH-1:0] id_write_addr,
    input  logic                      wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
    input  logic                      flush,
    output logic                      stall,
    output logic                      issue,
    output logic [REG_COUNT-1:0]      busy_mask,
    output logic                      err
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] pending      [REG_COUNT];
    logic [CNT_WIDTH-1:0] pending_next [REG_COUNT];
    logic [REG_COUNT-1:0] busy_next;

    logic [CNT_WIDTH-1:0] p_rd1;
    logic [CNT_WIDTH-1:0] p_rd2;
    logic [CNT_WIDTH-1:0] p_wr;
    logic [CNT_WIDTH-1:0] p_wb;

    logic raw_1;
    logic raw_2;
    logic sat;
    logic err_set;

    // Count lookups; register 0 and out-of-range addresses read as zero.
    always_comb begin
        p_rd1 = '0;
        p_rd2 = '0;
        p_wr  = '0;
        p_wb  = '0;
        for (int unsigned r = 1; r < REG_COUNT; r++) begin
            if (id_read_addr_1 == REG_ADDR_WIDTH'(r)) p_rd1 = pending[r];
            if (id_read_addr_2 == REG_ADDR_WIDTH'(r)) p_rd2 = pending[r];
            if (id_write_addr  == REG_ADDR_WIDTH'(r)) p_wr  = pending[r];
            if (wb_addr        == REG_ADDR_WIDTH'(r)) p_wb  = pending[r];
        end
    end

    // Hazard detection; a retire of the last outstanding write may bypass the hazard.
    always_comb begin
        raw_1 = id_read_en_1 && (id_read_addr_1 != '0) && (p_rd1 != '0);
        raw_2 = id_read_en_2 && (id_read_addr_2 != '0) && (p_rd2 != '0);
        if (BYPASS_WB == 1) begin
            if (wb_valid && (wb_addr == id_read_addr_1) && (p_rd1 == CNT_ONE)) raw_1 = 1'b0;
            if (wb_valid && (wb_addr == id_read_addr_2) && (p_rd2 == CNT_ONE)) raw_2 = 1'b0;
        end
        sat = id_write_en && (id_write_addr != '0) && (p_wr == CNT_MAX)
              && !(wb_valid && (wb_addr == id_write_addr));
    end

    assign stall = !rst || flush || (id_valid && (raw_1 || raw_2 || sat));
    assign issue = id_valid && !stall;

    assign err_set = wb_valid && (wb_addr != '0) && (p_wb == '0);

    // Next counter values for the non-flush case.
    always_comb begin
        pending_next[0] = '0;
        busy_next       = '0;
        for (int unsigned r = 1; r < REG_COUNT; r++) begin
            logic inc;
            logic dec;
            inc = issue && id_write_en && (id_write_addr == REG_ADDR_WIDTH'(r));
            dec = wb_valid && (wb_addr == REG_ADDR_WIDTH'(r)) && (pending[r] != '0);
            pending_next[r] = pending[r];
            if (inc && !dec)      pending_next[r] = pending[r] + CNT_ONE;
            else if (dec && !inc) pending_next[r] = pending[r] - CNT_ONE;
            busy_next[r] = (pending_next[r] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned r = 0; r < REG_COUNT; r++) pending[r] <= '0;
            busy_mask <= '0;
            err       <= 1'b0;
        end else if (flush) begin
            for (int unsigned r = 0; r < REG_COUNT; r++) pending[r] <= '0;
            busy_mask <= '0;
        end else begin
            for (int unsigned r = 0; r < REG_COUNT; r++) pending[r] <= pending_next[r];
            busy_mask <= busy_next;
            err       <= err || err_set;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed vector bench for reg_scoreboard; a second instance without write-back
// bypass shares the stimulus and has its stall checked separately.
module tb_reg_scoreboard;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic        id_read_en_1;
    logic [4:0]  id_read_addr_1;
    logic        id_read_en_2;
    logic [4:0]  id_read_addr_2;
    logic        id_write_en;
    logic [4:0]  id_write_addr;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic        flush;
    logic        stall;
    logic        issue;
    logic [31:0] busy_mask;
    logic        err;
    logic        stall_nb;
    logic        issue_nb;
    logic [31:0] busy_mask_nb;
    logic        err_nb;

    int checks = 0;
    int errors = 0;

    reg_scoreboard #(.REG_ADDR_WIDTH(5), .REG_COUNT(32), .CNT_WIDTH(2), .BYPASS_WB(1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_read_en_1(id_read_en_1), .id_read_addr_1(id_read_addr_1),
        .id_read_en_2(id_read_en_2), .id_read_addr_2(id_read_addr_2),
        .id_write_en(id_write_en), .id_write_addr(id_write_addr),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
        .stall(stall), .issue(issue), .busy_mask(busy_mask), .err(err)
    );

    reg_scoreboard #(.REG_ADDR_WIDTH(5), .REG_COUNT(32), .CNT_WIDTH(2), .BYPASS_WB(0)) dut_nb (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_read_en_1(id_read_en_1), .id_read_addr_1(id_read_addr_1),
        .id_read_en_2(id_read_en_2), .id_read_addr_2(id_read_addr_2),
        .id_write_en(id_write_en), .id_write_addr(id_write_addr),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
        .stall(stall_nb), .issue(issue_nb), .busy_mask(busy_mask_nb), .err(err_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        idv;
        logic        re1;
        logic [4:0]  ra1;
        logic        re2;
        logic [4:0]  ra2;
        logic        we;
        logic [4:0]  wa;
        logic        wbv;
        logic [4:0]  wba;
        logic        fl;
        logic        exp_stall;
        logic        exp_issue;
        logic        exp_stall_nb;
        logic [31:0] exp_busy;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic r, logic iv, logic r1e, logic [4:0] r1a,
                                logic r2e, logic [4:0] r2a, logic w, logic [4:0] wad,
                                logic bv, logic [4:0] ba, logic f, logic s, logic i,
                                logic snb, logic [31:0] b, logic e);
        vec_t v;
        v.name = n; v.rst = r; v.idv = iv; v.re1 = r1e; v.ra1 = r1a; v.re2 = r2e; v.ra2 = r2a;
        v.we = w; v.wa = wad; v.wbv = bv; v.wba = ba; v.fl = f;
        v.exp_stall = s; v.exp_issue = i; v.exp_stall_nb = snb; v.exp_busy = b; v.exp_err = e;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic r, logic iv, logic r1e, logic [4:0] r1a, logic r2e,
                         logic [4:0] r2a, logic w, logic [4:0] wad, logic bv,
                         logic [4:0] ba, logic f);
        rst = r; id_valid = iv; id_read_en_1 = r1e; id_read_addr_1 = r1a;
        id_read_en_2 = r2e; id_read_addr_2 = r2a; id_write_en = w; id_write_addr = wad;
        wb_valid = bv; wb_addr = ba; flush = f;
    endtask

    localparam logic [31:0] B3  = 32'h0000_0008;
    localparam logic [31:0] B5  = 32'h0000_0020;
    localparam logic [31:0] B7  = 32'h0000_0080;
    localparam logic [31:0] B9  = 32'h0000_0200;
    localparam logic [31:0] B20 = 32'h0010_0000;

    initial begin
        //          name          rst iv r1 a1  r2 a2  we wa  wb wba fl  st is snb busy     err
        vecs.push_back(mk("rst0",      0, 0, 0, 0,  0, 0,  0, 0,  0, 0,  0,  1, 0, 1, 0,       0));
        vecs.push_back(mk("rst1",      0, 0, 0, 0,  0, 0,  0, 0,  0, 0,  0,  1, 0, 1, 0,       0));
        vecs.push_back(mk("idle",      1, 0, 0, 0,  0, 0,  0, 0,  0, 0,  0,  0, 0, 0, 0,       0));
        vecs.push_back(mk("wr_r5",     1, 1, 0, 0,  0, 0,  1, 5,  0, 0,  0,  0, 1, 0, B5,      0));
        vecs.push_back(mk("raw_c1",    1, 1, 0, 0,  1, 5,  0, 0,  0, 0,  0,  1, 0, 1, B5,      0));
        vecs.push_back(mk("raw_c2",    1, 1, 0, 0,  1, 5,  0, 0,  0, 0,  0,  1, 0, 1, B5,      0));
        vecs.push_back(mk("raw_wb",    1, 1, 0, 0,  1, 5,  0, 0,  1, 5,  0,  0, 1, 1, 0,       0));
        vecs.push_back(mk("raw_c4",    1, 1, 0, 0,  1, 5,  0, 0,  0, 0,  0,  0, 1, 0, 0,       0));
        vecs.push_back(mk("sat_w1",    1, 1, 0, 0,  0, 0,  1, 7,  0, 0,  0,  0, 1, 0, B7,      0));
        vecs.push_back(mk("sat_w2",    1, 1, 0, 0,  0, 0,  1, 7,  0, 0,  0,  0, 1, 0, B7,      0));
        vecs.push_back(mk("sat_w3",    1, 1, 0, 0,  0, 0,  1, 7,  0, 0,  0,  0, 1, 0, B7,      0));
        vecs.push_back(mk("sat_w4",    1, 1, 0, 0,  0, 0,  1, 7,  0, 0,  0,  1, 0, 1, B7,      0));
        vecs.push_back(mk("sat_w4wb",  1, 1, 0, 0,  0, 0,  1, 7,  1, 7,  0,  0, 1, 0, B7,      0));
        vecs.push_back(mk("sat_rt3",   1, 0, 0, 0,  0, 0,  0, 0,  1, 7,  0,  0, 0, 0, B7,      0));
        vecs.push_back(mk("sat_rt2",   1, 0, 0, 0,  0, 0,  0, 0,  1, 7,  0,  0, 0, 0, B7,      0));
        vecs.push_back(mk("sat_rt1",   1, 0, 0, 0,  0, 0,  0, 0,  1, 7,  0,  0, 0, 0, 0,       0));
        vecs.push_back(mk("r0_wr",     1, 1, 0, 0,  0, 0,  1, 0,  0, 0,  0,  0, 1, 0, 0,       0));
        vecs.push_back(mk("r0_rd",     1, 1, 1, 0,  1, 0,  0, 0,  0, 0,  0,  0, 1, 0, 0,       0));
        vecs.push_back(mk("r0_wb",     1, 0, 0, 0,  0, 0,  0, 0,  1, 0,  0,  0, 0, 0, 0,       0));
        vecs.push_back(mk("fl_w3a",    1, 1, 0, 0,  0, 0,  1, 3,  0, 0,  0,  0, 1, 0, B3,      0));
        vecs.push_back(mk("fl_w3b",    1, 1, 0, 0,  0, 0,  1, 3,  0, 0,  0,  0, 1, 0, B3,      0));
        vecs.push_back(mk("fl_w9",     1, 1, 0, 0,  0, 0,  1, 9,  0, 0,  0,  0, 1, 0, B3|B9,   0));
        vecs.push_back(mk("flush",     1, 1, 0, 0,  0, 0,  1, 4,  0, 0,  1,  1, 0, 1, 0,       0));
        vecs.push_back(mk("fl_idle",   1, 0, 0, 0,  0, 0,  0, 0,  0, 0,  0,  0, 0, 0, 0,       0));
        vecs.push_back(mk("fl_rd3",    1, 1, 1, 3,  0, 0,  0, 0,  0, 0,  0,  0, 1, 0, 0,       0));
        vecs.push_back(mk("sp_w5",     1, 1, 0, 0,  0, 0,  1, 5,  0, 0,  0,  0, 1, 0, B5,      0));
        vecs.push_back(mk("sp_wb12",   1, 0, 0, 0,  0, 0,  0, 0,  1, 12, 0,  0, 0, 0, B5,      1));
        vecs.push_back(mk("sp_hold",   1, 0, 0, 0,  0, 0,  0, 0,  0, 0,  0,  0, 0, 0, B5,      1));
        vecs.push_back(mk("sp_flush",  1, 0, 0, 0,  0, 0,  0, 0,  0, 0,  1,  1, 0, 1, 0,       1));
        vecs.push_back(mk("sp_rst",    0, 0, 0, 0,  0, 0,  0, 0,  0, 0,  0,  1, 0, 1, 0,       0));
        vecs.push_back(mk("sp_idle",   1, 0, 0, 0,  0, 0,  0, 0,  0, 0,  0,  0, 0, 0, 0,       0));
        vecs.push_back(mk("w20",       1, 1, 0, 0,  0, 0,  1, 20, 0, 0,  0,  0, 1, 0, B20,     0));
        vecs.push_back(mk("rd20_nov",  1, 0, 1, 20, 0, 0,  0, 0,  0, 0,  0,  0, 0, 0, B20,     0));
        vecs.push_back(mk("raw_p1",    1, 1, 1, 20, 1, 1,  0, 0,  0, 0,  0,  1, 0, 1, B20,     0));
        vecs.push_back(mk("waw20",     1, 1, 0, 0,  0, 0,  1, 20, 0, 0,  0,  0, 1, 0, B20,     0));
        vecs.push_back(mk("wb_cnt2",   1, 1, 1, 20, 0, 0,  0, 0,  1, 20, 0,  1, 0, 1, B20,     0));
        vecs.push_back(mk("wb_cnt1",   1, 1, 1, 20, 0, 0,  0, 0,  1, 20, 0,  0, 1, 1, 0,       0));

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;

        foreach (vecs[n]) begin
            drive(vecs[n].rst, vecs[n].idv, vecs[n].re1, vecs[n].ra1, vecs[n].re2, vecs[n].ra2,
                  vecs[n].we, vecs[n].wa, vecs[n].wbv, vecs[n].wba, vecs[n].fl);
            #1;
            check({vecs[n].name, ".stall"},    32'(stall),    32'(vecs[n].exp_stall));
            check({vecs[n].name, ".issue"},    32'(issue),    32'(vecs[n].exp_issue));
            check({vecs[n].name, ".stall_nb"}, 32'(stall_nb), 32'(vecs[n].exp_stall_nb));
            @(posedge clk); #1;
            check({vecs[n].name, ".busy"},     busy_mask,     vecs[n].exp_busy);
            check({vecs[n].name, ".err"},      32'(err),      32'(vecs[n].exp_err));
        end

        // Fill every tracked register once, then retire them all.
        for (int r = 1; r < 32; r++) begin
            drive(1, 1, 0, 0, 0, 0, 1, 5'(r), 0, 0, 0);
            #1;
            check("fill.issue", 32'(issue), 32'd1);
            @(posedge clk); #1;
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("fill.busy", busy_mask, 32'hFFFF_FFFE);
        check("fill.busy_nb", busy_mask_nb, 32'hFFFF_FFFE);
        for (int r = 31; r >= 1; r--) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 5'(r), 0);
            @(posedge clk); #1;
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("drain.busy", busy_mask, 32'h0);
        check("drain.err", 32'(err), 32'd0);
        check("drain.stall", 32'(stall), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
